vref_sweep_ctrl: RTL and testbench

VREF_SWEEP_CTRL -- requirements
Module: vref_sweep_ctrl

---
 rtl/vref_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_vref_sweep_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vref_sweep_ctrl.sv
// vref_sweep_ctrl
// Sweeps the receiver vref code 0..15, runs one point test per code and keeps
// the longest contiguous run of passing codes (lowest code wins a tie). The
// final code is the centre of that run, or DEFAULT_CODE when nothing passed.
//
// Parameters:
//   SETTLE_CYCLES  idle cycles after each code change before the point test (1..255)
//   DEFAULT_CODE   code used at reset, on abort and when no code passes
//
// Ports:
//   clk                rising-edge clock
//   rst_n              asynchronous active-low reset
//   i_en               sweep enable; dropping it mid-sweep aborts
//   i_pt_done          point-test completion pulse, result valid in the same cycle
//   i_rx_lanes_result  per-lane pass flags (1 = pass)
//   i_lane_mask        lanes that take part in the pass decision
//                      (present only with VREF_SWEEP_LANE_MASK_EN)
//   o_pt_start         single-cycle point-test start pulse
//   o_vref_code        receiver reference voltage control word
//   o_done             sweep complete (level)
//   o_cal_pass         at least one passing code found, valid while o_done=1
//
// Build option: define VREF_SWEEP_LANE_MASK_EN to add i_lane_mask.
module vref_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter logic [3:0]  DEFAULT_CODE  = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_pt_done,
  input  logic [15:0] i_rx_lanes_result,
`ifdef VREF_SWEEP_LANE_MASK_EN
  input  logic [15:0] i_lane_mask,
`endif
  output logic        o_pt_start,
  output logic [3:0]  o_vref_code,
  output logic        o_done,
  output logic        o_cal_pass
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SET_CODE = 3'd1,
    SETTLE   = 3'd2,
    START_PT = 3'd3,
    WAIT_PT  = 3'd4,
    EVAL     = 3'd5,
    FINALIZE = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic [7:0]  settle_cnt_r, settle_cnt_s;
  logic        pt_pass_r, pt_pass_s;
  logic [3:0]  run_start_r, run_start_s;
  logic [4:0]  run_len_r, run_len_s;
  logic [3:0]  best_start_r, best_start_s;
  logic [4:0]  best_len_r, best_len_s;
  logic        pt_start_s;
  logic [3:0]  vref_code_s;
  logic        done_s;
  logic        cal_pass_s;
  logic [15:0] lane_mask_s;
  logic        abort_s;
  logic        close_s;
  logic [3:0]  ext_start_s;
  logic [4:0]  ext_len_s;
  logic [3:0]  center_s;

  // A code passes when every participating lane reports pass.
  function automatic logic lanes_pass(input logic [15:0] result, input logic [15:0] mask);
    lanes_pass = &(result | ~mask);
  endfunction

`ifdef VREF_SWEEP_LANE_MASK_EN
  assign lane_mask_s = i_lane_mask;
`else
  assign lane_mask_s = 16'hFFFF;
`endif

  // Next-state, tracker and output-register next values.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    settle_cnt_s = settle_cnt_r;
    pt_pass_s    = pt_pass_r;
    run_start_s  = run_start_r;
    run_len_s    = run_len_r;
    best_start_s = best_start_r;
    best_len_s   = best_len_r;
    pt_start_s   = 1'b0;
    vref_code_s  = o_vref_code;
    done_s       = 1'b0;
    cal_pass_s   = o_cal_pass;
    close_s      = 1'b0;

    // Current run as it would look after folding in the latched result.
    ext_len_s   = pt_pass_r ? (run_len_r + 5'd1) : run_len_r;
    ext_start_s = (pt_pass_r && (run_len_r == 5'd0)) ? idx_r : run_start_r;
    // Centre of the best run; (len-1)>>1 is at most 7 so it fits 4 bits.
    center_s    = best_start_r + 4'((best_len_r - 5'd1) >> 1);

    // SET_CODE is not abortable; every later sweep state is.
    abort_s = !i_en && (state_r inside {SETTLE, START_PT, WAIT_PT, EVAL, FINALIZE});

    if (abort_s) begin
      state_s     = IDLE;
      vref_code_s = DEFAULT_CODE;
      cal_pass_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cal_pass_s = 1'b0;
          if (i_en) begin
            state_s      = SET_CODE;
            idx_s        = 4'd0;
            settle_cnt_s = 8'd0;
            pt_pass_s    = 1'b0;
            run_start_s  = 4'd0;
            run_len_s    = 5'd0;
            best_start_s = 4'd0;
            best_len_s   = 5'd0;
            vref_code_s  = 4'd0;
          end else begin
            state_s = IDLE;
          end
        end
        SET_CODE: begin
          state_s      = SETTLE;
          settle_cnt_s = 8'd0;
        end
        SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            state_s    = START_PT;
            pt_start_s = 1'b1;
          end else begin
            settle_cnt_s = settle_cnt_r + 8'd1;
          end
        end
        START_PT: begin
          state_s = WAIT_PT;
        end
        WAIT_PT: begin
          if (i_pt_done) begin
            pt_pass_s = lanes_pass(i_rx_lanes_result, lane_mask_s);
            state_s   = EVAL;
          end else begin
            state_s = WAIT_PT;
          end
        end
        EVAL: begin
          // A failing code, or the last code, closes the run.
          close_s = !pt_pass_r || (idx_r == 4'd15);
          if (close_s) begin
            if (ext_len_s > best_len_r) begin
              best_start_s = ext_start_s;
              best_len_s   = ext_len_s;
            end else begin
              best_len_s = best_len_r;
            end
            run_start_s = 4'd0;
            run_len_s   = 5'd0;
          end else begin
            run_start_s = ext_start_s;
            run_len_s   = ext_len_s;
          end
          if (idx_r == 4'd15) begin
            state_s = FINALIZE;
          end else begin
            idx_s       = idx_r + 4'd1;
            vref_code_s = idx_r + 4'd1;
            state_s     = SET_CODE;
          end
        end
        FINALIZE: begin
          state_s = DONE;
          done_s  = 1'b1;
          if (best_len_r != 5'd0) begin
            vref_code_s = center_s;
            cal_pass_s  = 1'b1;
          end else begin
            vref_code_s = DEFAULT_CODE;
            cal_pass_s  = 1'b0;
          end
        end
        DONE: begin
          if (!i_en) begin
            state_s    = IDLE;
            cal_pass_s = 1'b0;
          end else begin
            done_s = 1'b1;
          end
        end
        default: begin
          state_s     = IDLE;
          vref_code_s = DEFAULT_CODE;
          cal_pass_s  = 1'b0;
        end
      endcase
    end
  end

  // State, trackers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= 4'd0;
      settle_cnt_r <= 8'd0;
      pt_pass_r    <= 1'b0;
      run_start_r  <= 4'd0;
      run_len_r    <= 5'd0;
      best_start_r <= 4'd0;
      best_len_r   <= 5'd0;
      o_pt_start   <= 1'b0;
      o_vref_code  <= DEFAULT_CODE;
      o_done       <= 1'b0;
      o_cal_pass   <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      settle_cnt_r <= settle_cnt_s;
      pt_pass_r    <= pt_pass_s;
      run_start_r  <= run_start_s;
      run_len_r    <= run_len_s;
      best_start_r <= best_start_s;
      best_len_r   <= best_len_s;
      o_pt_start   <= pt_start_s;
      o_vref_code  <= vref_code_s;
      o_done       <= done_s;
      o_cal_pass   <= cal_pass_s;
    end
  end

endmodule

// File: tb/tb_vref_sweep_ctrl.sv
// Self-checking bench for vref_sweep_ctrl: a table of per-code pass patterns
// with expected results, randomized patterns checked against a brute-force
// longest-run model, and hand-written abort / reset sequences.
module tb_vref_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_en;
  logic        i_pt_done;
  logic [15:0] i_rx_lanes_result;
`ifdef VREF_SWEEP_LANE_MASK_EN
  logic [15:0] i_lane_mask;
`endif
  logic        o_pt_start;
  logic [3:0]  o_vref_code;
  logic        o_done;
  logic        o_cal_pass;

  int total;
  int bad;

  typedef struct {
    logic [15:0] pass_codes;
    logic [3:0]  exp_code;
    logic        exp_cal;
  } vec_t;

  vec_t vecs[9];

  vref_sweep_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_en              (i_en),
    .i_pt_done         (i_pt_done),
    .i_rx_lanes_result (i_rx_lanes_result),
`ifdef VREF_SWEEP_LANE_MASK_EN
    .i_lane_mask       (i_lane_mask),
`endif
    .o_pt_start        (o_pt_start),
    .o_vref_code       (o_vref_code),
    .o_done            (o_done),
    .o_cal_pass        (o_cal_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: brute-force search over every [s,e] window of passing codes;
  // the first strictly-longer window wins, so ties go to the lowest code.
  function automatic void ref_cal(input logic [15:0] pc, output logic [3:0] code, output logic cal);
    int best_len;
    int best_start;
    bit all_ok;
    best_len   = 0;
    best_start = 0;
    for (int s = 0; s < 16; s++) begin
      for (int e = s; e < 16; e++) begin
        all_ok = 1'b1;
        for (int k = s; k <= e; k++) begin
          if (!pc[k]) all_ok = 1'b0;
        end
        if (all_ok && (e - s + 1) > best_len) begin
          best_len   = e - s + 1;
          best_start = s;
        end
      end
    end
    if (best_len > 0) begin
      code = 4'(best_start + (best_len - 1) / 2);
      cal  = 1'b1;
    end else begin
      code = 4'd8;
      cal  = 1'b0;
    end
  endfunction

  // Runs one sweep acting as the point-test responder. pass_codes bit n says
  // whether code n passes. When the sweep reaches abort_code, i_en is dropped
  // together with i_pt_done and the task returns.
  task automatic run_sweep(input logic [15:0] pass_codes, input logic [15:0] mask_v,
                           input int abort_code, output logic [3:0] code_o,
                           output logic cal_o, output int pulses_o, output logic done_o);
    int idx;
    int cyc;
    int pos;
    logic [15:0] r;
    idx      = 0;
    cyc      = 0;
    pulses_o = 0;
    done_o   = 1'b0;
    code_o   = 4'd0;
    cal_o    = 1'b0;
`ifdef VREF_SWEEP_LANE_MASK_EN
    i_lane_mask = mask_v;
`endif
    i_en = 1'b1;
    while (cyc < 3000 && !done_o) begin
      tick();
      cyc++;
      if (o_done) begin
        done_o = 1'b1;
        code_o = o_vref_code;
        cal_o  = o_cal_pass;
      end else if (o_pt_start) begin
        if (pulses_o == 0) chk("settle_latency", cyc, 10);
        chk("sweep_code", o_vref_code, idx[3:0]);
        pulses_o++;
        i_pt_done = 1'b0;
        tick();
        cyc++;
        chk("pt_start_width", o_pt_start, 1'b0);
        if (pass_codes[idx[3:0]]) begin
          r = mask_v;
        end else begin
          pos = $urandom_range(0, 7);
          r = 16'($urandom) & mask_v & ~(16'h0001 << pos);
        end
        i_rx_lanes_result = r;
        if (idx == abort_code) begin
          i_pt_done = 1'b1;
          i_en      = 1'b0;
          tick();
          chk("abort_code", o_vref_code, 4'd8);
          chk("abort_done", o_done, 1'b0);
          chk("abort_pt_start", o_pt_start, 1'b0);
          i_pt_done = 1'b0;
          return;
        end
        repeat ($urandom_range(0, 2)) begin
          tick();
          cyc++;
        end
        i_pt_done = 1'b1;
        tick();
        cyc++;
        i_pt_done = 1'b0;
        i_rx_lanes_result = 16'($urandom);
        idx++;
      end else begin
        // Stray completion pulses outside WAIT_PT must be ignored.
        i_pt_done = ($urandom_range(0, 3) == 0);
        i_rx_lanes_result = 16'h0000;
      end
    end
    i_pt_done = 1'b0;
  endtask

  task automatic sweep_check(input string tag, input logic [15:0] pc, input logic [15:0] mask_v,
                             input logic [3:0] exp_code, input logic exp_cal);
    logic [3:0] code;
    logic       cal;
    int         pulses;
    logic       done;
    run_sweep(pc, mask_v, -1, code, cal, pulses, done);
    chk({tag, "/done"}, done, 1'b1);
    chk({tag, "/pulses"}, pulses, 16);
    chk({tag, "/code"}, code, exp_code);
    chk({tag, "/cal_pass"}, cal, exp_cal);
    i_en = 1'b0;
    tick();
    chk({tag, "/idle_done"}, o_done, 1'b0);
    chk({tag, "/idle_cal"}, o_cal_pass, 1'b0);
    chk({tag, "/idle_code_held"}, o_vref_code, exp_code);
  endtask

  initial begin
    logic [15:0] pc;
    logic [3:0]  m_code;
    logic        m_cal;
    logic [3:0]  a_code;
    logic        a_cal;
    int          a_pulses;
    logic        a_done;

    total = 0;
    bad   = 0;
    vecs[0] = '{16'h07E0, 4'd7,  1'b1};
    vecs[1] = '{16'h0E1C, 4'd3,  1'b1};
    vecs[2] = '{16'hF003, 4'd13, 1'b1};
    vecs[3] = '{16'h0000, 4'd8,  1'b0};
    vecs[4] = '{16'hFFFF, 4'd7,  1'b1};
    vecs[5] = '{16'h8000, 4'd15, 1'b1};
    vecs[6] = '{16'h0001, 4'd0,  1'b1};
    vecs[7] = '{16'h5555, 4'd0,  1'b1};
    vecs[8] = '{16'hFFFE, 4'd8,  1'b1};

    rst_n = 1'b0;
    i_en = 1'b0;
    i_pt_done = 1'b0;
    i_rx_lanes_result = 16'h0000;
`ifdef VREF_SWEEP_LANE_MASK_EN
    i_lane_mask = 16'hFFFF;
`endif

    repeat (2) tick();
    chk("rst_pt_start", o_pt_start, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_cal", o_cal_pass, 1'b0);
    chk("rst_code", o_vref_code, 4'd8);
    rst_n = 1'b1;
    tick();
    chk("idle_code", o_vref_code, 4'd8);
    chk("idle_pt_start", o_pt_start, 1'b0);

    // Table vectors.
    for (int i = 0; i < 9; i++) begin
      sweep_check($sformatf("vec%0d", i), vecs[i].pass_codes, 16'hFFFF,
                  vecs[i].exp_code, vecs[i].exp_cal);
    end

    // Abort in WAIT_PT for code 6 with a simultaneous completion pulse.
    run_sweep(16'h07E0, 16'hFFFF, 6, a_code, a_cal, a_pulses, a_done);
    chk("abort_pulses", a_pulses, 7);
    tick();
    chk("abort_stays_idle", o_pt_start, 1'b0);
    chk("abort_code_held", o_vref_code, 4'd8);
    sweep_check("restart", 16'h07E0, 16'hFFFF, 4'd7, 1'b1);

    // Reset asserted during SETTLE acts without a clock edge.
    i_en = 1'b1;
    tick();
    chk("pre_rst_code", o_vref_code, 4'd0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_code", o_vref_code, 4'd8);
    chk("async_rst_pt_start", o_pt_start, 1'b0);
    chk("async_rst_done", o_done, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_no_action", o_vref_code, 4'd8);
    tick();
    chk("post_rst_first_code", o_vref_code, 4'd0);
    i_en = 1'b0;
    tick();
    tick();
    chk("post_rst_abort_code", o_vref_code, 4'd8);
    chk("post_rst_abort_done", o_done, 1'b0);

    // Randomized patterns against the reference model.
    for (int n = 0; n < 12; n++) begin
      case (n % 3)
        0:       pc = 16'($urandom);
        1:       pc = 16'($urandom) | 16'($urandom);
        default: pc = 16'($urandom) & 16'($urandom);
      endcase
      ref_cal(pc, m_code, m_cal);
      sweep_check($sformatf("rand%0d_%04h", n, pc), pc, 16'hFFFF, m_code, m_cal);
    end

`ifdef VREF_SWEEP_LANE_MASK_EN
    // Lanes 8..15 always fail but are masked; lanes 0..7 pass on codes 3..6.
    sweep_check("lane_mask", 16'h0078, 16'h00FF, 4'd4, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
